// File: rtl/chacha_ctrl_pkg.sv
// Shared types and helpers for the ChaCha block sequencer.
package chacha_ctrl_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int BLOCK_BITS      = 512;
  localparam int WORD_BITS       = BLOCK_BITS / WORDS_PER_BLOCK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [WORD_BITS-1:0] word_sel(input logic [BLOCK_BITS-1:0] blk,
                                                    input logic [3:0]            idx);
    return blk[BLOCK_BITS-1 - WORD_BITS*int'(idx) -: WORD_BITS];
  endfunction

endpackage

// File: rtl/chacha_ks_unpacker.sv
// Captures one 512-bit keystream block and streams it out as 16 words
// through a registered valid/ready stage.
module chacha_ks_unpacker
  import chacha_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [BLOCK_BITS-1:0] blk,
  input  logic                  ks_ready,
  output logic                  ks_valid,
  output logic [WORD_W-1:0]     ks_data,
  output logic                  last_acc
);

  logic [BLOCK_BITS-1:0] blk_q;
  logic [3:0]            idx;
  logic                  acc;

  assign acc      = ks_valid && ks_ready;
  assign last_acc = acc && (idx == 4'(WORDS_PER_BLOCK - 1));

  // Capture register, word index and output stage; data only moves on accept
  // so the word stays stable across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      idx      <= '0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
    end else if (flush) begin
      ks_valid <= 1'b0;
    end else if (load) begin
      blk_q    <= blk;
      idx      <= '0;
      ks_valid <= 1'b1;
      ks_data  <= word_sel(blk, 4'd0);
    end else if (acc) begin
      if (last_acc) begin
        ks_valid <= 1'b0;
      end else begin
        idx     <= idx + 4'd1;
        ks_data <= word_sel(blk_q, idx + 4'd1);
      end
    end
  end

endmodule

// File: rtl/chacha_block_sequencer.sv
// Sequences the ChaCha core: issues init/next per block, captures each
// keystream block and streams it out, reporting status to the register file.
module chacha_block_sequencer
  import chacha_ctrl_pkg::*;
#(
  parameter int CTR_W  = 64,
  parameter int CNT_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  input  logic [CTR_W-1:0]      cfg_ctr_init,
  input  logic [CNT_W-1:0]      cfg_num_blocks,
  output logic                  core_init,
  output logic                  core_next,
  output logic [CTR_W-1:0]      core_ctr,
  input  logic                  core_ready,
  input  logic                  core_data_valid,
  input  logic [BLOCK_BITS-1:0] core_data,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic [WORD_W-1:0]     ks_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  start_err,
  output logic                  ctr_wrap,
  output logic [CNT_W-1:0]      blocks_done
);

  state_t           state, state_nx;
  logic             first;
  logic [CNT_W-1:0] num_blocks;
  logic [CNT_W-1:0] bd_inc;
  logic             active, start_acc, issue_go;
  logic             load, flush, last_acc;

  assign active    = (state != S_IDLE);
  assign start_acc = !active && cmd_start && !cmd_abort;
  assign bd_inc    = blocks_done + 1'b1;

  // Command pulses are qualified by core_ready directly so the issue costs no
  // extra cycle; an abort in the same cycle suppresses the command.
  assign issue_go  = (state == S_ISSUE) && core_ready && !cmd_abort;
  assign core_init = issue_go && first;
  assign core_next = issue_go && !first;

  // Next-state logic; abort from any active state wins over everything.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    flush    = 1'b0;
    if (active && cmd_abort) begin
      state_nx = S_IDLE;
      flush    = 1'b1;
    end else begin
      case (state)
        S_IDLE:  if (start_acc && (cfg_num_blocks != '0)) state_nx = S_ISSUE;
        S_ISSUE: if (core_ready) state_nx = S_WAIT;
        S_WAIT:  if (core_data_valid) begin
                   load     = 1'b1;
                   state_nx = S_DRAIN;
                 end
        S_DRAIN: if (last_acc) state_nx = (bd_inc == num_blocks) ? S_DONE : S_ISSUE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Sequence bookkeeping and registered status outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      first       <= 1'b0;
      num_blocks  <= '0;
      core_ctr    <= '0;
      ctr_wrap    <= 1'b0;
      blocks_done <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      start_err   <= 1'b0;
    end else begin
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
      aborted   <= active && cmd_abort;
      start_err <= active && cmd_start && !cmd_abort;
      if (start_acc) begin
        num_blocks  <= cfg_num_blocks;
        core_ctr    <= cfg_ctr_init;
        blocks_done <= '0;
        ctr_wrap    <= 1'b0;
        first       <= 1'b1;
        if (cfg_num_blocks == '0) done <= 1'b1;
      end
      if (issue_go) first <= 1'b0;
      // A block counts once downstream has taken all sixteen words.
      if (last_acc) begin
        blocks_done <= bd_inc;
        core_ctr    <= core_ctr + 1'b1;
        if (&core_ctr) ctr_wrap <= 1'b1;
      end
    end
  end

  chacha_ks_unpacker #(.WORD_W(WORD_W)) u_unpack (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (load),
    .flush    (flush),
    .blk      (core_data),
    .ks_ready (ks_ready),
    .ks_valid (ks_valid),
    .ks_data  (ks_data),
    .last_acc (last_acc)
  );

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Directed bench for chacha_block_sequencer with a core model and a
// transaction-level reference model checked every cycle.
module tb_chacha_block_sequencer;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [63:0]  cfg_ctr_init = '0;
  logic [15:0]  cfg_num_blocks = '0;
  logic         core_init, core_next;
  logic [63:0]  core_ctr;
  logic         core_ready = 1'b1, core_data_valid = 1'b0;
  logic [511:0] core_data = '0;
  logic         ks_valid, ks_ready = 1'b1;
  logic [31:0]  ks_data;
  logic         busy, done, aborted, start_err, ctr_wrap;
  logic [15:0]  blocks_done;

  int tests = 0, fails = 0;
  int done_cnt = 0, abt_cnt = 0, serr_cnt = 0;
  logic [31:0] wlog[$];
  logic [63:0] clog_ctr[$];
  bit          clog_init[$];
  logic [31:0] exp_q[$];

  chacha_block_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_ctr_init(cfg_ctr_init), .cfg_num_blocks(cfg_num_blocks),
    .core_init(core_init), .core_next(core_next), .core_ctr(core_ctr),
    .core_ready(core_ready), .core_data_valid(core_data_valid), .core_data(core_data),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .busy(busy), .done(done), .aborted(aborted), .start_err(start_err),
    .ctr_wrap(ctr_wrap), .blocks_done(blocks_done)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Keystream block for a counter: bytes 0x00..0x3F, each word xored with ctr[31:0].
  function automatic logic [511:0] mk_blk(input logic [63:0] ctr);
    logic [511:0] b;
    for (int j = 0; j < 64; j++) b[511-8*j -: 8] = 8'(j);
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = b[511-32*i -: 32] ^ ctr[31:0];
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] ctr, input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} ^ ctr[31:0];
  endfunction

  // Core model: accepts a command, goes not-ready, returns the block 3 cycles later.
  initial begin : core_model
    logic [63:0] cctr;
    forever begin
      @(negedge ACLK);
      if (ARESETN && (core_init || core_next)) begin
        cctr = core_ctr;
        @(posedge ACLK); #1 core_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 core_data = mk_blk(cctr); core_data_valid = 1'b1;
        @(posedge ACLK); #1 core_data_valid = 1'b0; core_ready = 1'b1;
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin : monitor
    logic [63:0] m_ctr;
    logic [15:0] m_num, m_bd;
    logic [31:0] prev_data;
    bit m_busy, m_tail, m_first, m_wrap, m_done, m_abt, m_serr, m_pv, prev_stall;
    bit n_done, n_abt, n_serr;
    m_ctr = '0; m_num = '0; m_bd = '0; prev_data = '0;
    m_busy = 0; m_tail = 0; m_first = 0; m_wrap = 0;
    m_done = 0; m_abt = 0; m_serr = 0; m_pv = 0; prev_stall = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        m_ctr = '0; m_bd = '0; m_busy = 0; m_tail = 0; m_wrap = 0;
        m_done = 0; m_abt = 0; m_serr = 0; m_pv = 0; prev_stall = 0;
        exp_q.delete();
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0); chk("rst_start_err", start_err, 0);
        chk("rst_ks_valid", ks_valid, 0); chk("rst_ks_data", ks_data, 0);
        chk("rst_core_ctr", core_ctr, 0); chk("rst_ctr_wrap", ctr_wrap, 0);
        chk("rst_blocks_done", blocks_done, 0);
        chk("rst_core_cmd", {core_init, core_next}, 0);
        continue;
      end
      chk("busy", busy, m_busy);            chk("done", done, m_done);
      chk("aborted", aborted, m_abt);       chk("start_err", start_err, m_serr);
      chk("blocks_done", blocks_done, m_bd); chk("ctr_wrap", ctr_wrap, m_wrap);
      chk("core_ctr", core_ctr, m_ctr);
      if (!m_busy || m_tail) chk("ks_valid_idle", ks_valid, 0);
      if (m_pv) chk("ks_valid_after_data", ks_valid, 1);
      if (prev_stall) begin
        chk("stall_valid", ks_valid, 1);
        chk("stall_data", ks_data, prev_data);
      end
      if (done) done_cnt++;
      if (aborted) abt_cnt++;
      if (start_err) serr_cnt++;

      n_done = 0; n_abt = 0; n_serr = 0; prev_stall = 0; m_pv = 0;
      if (!m_busy) begin
        if (cmd_start && !cmd_abort) begin
          m_wrap = 0; m_bd = '0; m_num = cfg_num_blocks; m_ctr = cfg_ctr_init;
          m_first = 1; exp_q.delete();
          if (cfg_num_blocks == 0) n_done = 1; else m_busy = 1;
        end
      end else if (m_tail) begin
        if (cmd_abort) n_abt = 1; else if (cmd_start) n_serr = 1;
        m_busy = 0; m_tail = 0;
      end else begin
        if (core_init || core_next) begin
          chk("cmd_is_init", core_init, m_first);
          chk("cmd_ctr", core_ctr, m_ctr);
          clog_ctr.push_back(core_ctr);
          clog_init.push_back(core_init);
          for (int i = 0; i < 16; i++) exp_q.push_back(exp_word(m_ctr, i));
          m_first = 0;
        end
        if (core_data_valid && !ks_valid && exp_q.size() == 16) m_pv = 1;
        if (ks_valid && ks_ready) begin
          wlog.push_back(ks_data);
          if (exp_q.size() == 0) chk("spurious_word", ks_valid, 0);
          else begin
            chk("ks_data", ks_data, exp_q.pop_front());
            if (exp_q.size() == 0) begin
              m_bd++;
              if (&m_ctr) m_wrap = 1;
              m_ctr++;
              if (m_bd == m_num) begin m_tail = 1; n_done = 1; end
            end
          end
        end else if (ks_valid) begin
          prev_stall = 1; prev_data = ks_data;
        end
        if (cmd_abort) begin
          n_abt = 1; m_busy = 0; m_tail = 0; exp_q.delete(); prev_stall = 0; m_pv = 0;
        end else if (cmd_start) n_serr = 1;
      end
      m_done = n_done; m_abt = n_abt; m_serr = n_serr;
    end
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_start(input logic [63:0] ctr, input logic [15:0] num);
    cfg_ctr_init = ctr; cfg_num_blocks = num; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      ks_ready = toggle ? ~ks_ready : 1'b1;
      tick();
      n++;
    end
    chk({nm, "_timeout"}, busy, 0);
    ks_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin : stim
    int w0, c0, d0, a0, s0, n;
    #1;
    repeat (3) tick();
    ARESETN = 1'b1;
    tick();

    // One block from counter 0.
    w0 = wlog.size(); c0 = clog_ctr.size(); d0 = done_cnt;
    pulse_start(64'd0, 16'd1);
    wait_idle(0, "t1");
    chk("t1_nwords", wlog.size() - w0, 16);
    chk("t1_ncmds", clog_ctr.size() - c0, 1);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_blocks_done", blocks_done, 1);
    if (wlog.size() >= w0 + 16) begin
      chk("t1_first_word", wlog[w0], 32'h00010203);
      chk("t1_last_word", wlog[w0+15], 32'h3C3D3E3F);
    end
    if (clog_init.size() > c0) chk("t1_cmd_init", clog_init[c0], 1);

    // Three blocks from 5 with 50% backpressure.
    w0 = wlog.size(); c0 = clog_ctr.size(); d0 = done_cnt;
    pulse_start(64'd5, 16'd3);
    wait_idle(1, "t2");
    chk("t2_nwords", wlog.size() - w0, 48);
    chk("t2_done_cnt", done_cnt - d0, 1);
    if (clog_ctr.size() >= c0 + 3) begin
      chk("t2_ctr0", clog_ctr[c0], 5); chk("t2_ctr1", clog_ctr[c0+1], 6);
      chk("t2_ctr2", clog_ctr[c0+2], 7);
      chk("t2_kinds", {clog_init[c0], clog_init[c0+1], clog_init[c0+2]}, 3'b100);
    end else chk("t2_ncmds", clog_ctr.size() - c0, 3);
    if (wlog.size() >= w0 + 17) chk("t2_blk1_word0", wlog[w0+16], 32'h00010205);

    // Counter wrap.
    w0 = wlog.size(); c0 = clog_ctr.size();
    pulse_start(64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
    wait_idle(0, "t3");
    chk("t3_wrap", ctr_wrap, 1);
    chk("t3_core_ctr", core_ctr, 1);
    if (clog_ctr.size() >= c0 + 2) begin
      chk("t3_ctr0", clog_ctr[c0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_ctr1", clog_ctr[c0+1], 0);
    end else chk("t3_ncmds", clog_ctr.size() - c0, 2);
    if (wlog.size() > w0) chk("t3_word0", wlog[w0], 32'hFFFEFDFC);

    // Zero blocks: done only, and the start clears ctr_wrap.
    c0 = clog_ctr.size(); d0 = done_cnt;
    pulse_start(64'h1234, 16'd0);
    chk("t4_busy", busy, 0);
    tick(); tick();
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_ncmds", clog_ctr.size() - c0, 0);
    chk("t4_wrap_cleared", ctr_wrap, 0);

    // Start+abort together while idle is ignored entirely.
    d0 = done_cnt; a0 = abt_cnt;
    cfg_num_blocks = 16'd0; cmd_start = 1'b1; cmd_abort = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    tick();
    chk("t4b_no_done", done_cnt - d0, 0);
    chk("t4b_no_abort", abt_cnt - a0, 0);

    // Abort after 7 words of block 2 of 4.
    w0 = wlog.size(); d0 = done_cnt; a0 = abt_cnt; n = 0;
    pulse_start(64'd100, 16'd4);
    while (wlog.size() - w0 < 23 && n < 400) begin tick(); n++; end
    chk("t5_reach_timeout", wlog.size() - w0, 23);
    ks_ready = 1'b0; cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_ks_valid", ks_valid, 0);
    chk("t5_blocks_done", blocks_done, 1);
    chk("t5_abort_cnt", abt_cnt - a0, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    ks_ready = 1'b1;
    w0 = wlog.size(); d0 = done_cnt;
    pulse_start(64'd0, 16'd1);
    wait_idle(0, "t5b");
    chk("t5b_done_cnt", done_cnt - d0, 1);
    chk("t5b_nwords", wlog.size() - w0, 16);

    // Start while busy raises start_err without disturbing the sequence.
    w0 = wlog.size(); d0 = done_cnt; s0 = serr_cnt;
    pulse_start(64'd20, 16'd2);
    repeat (3) tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_idle(0, "t6");
    chk("t6_serr_cnt", serr_cnt - s0, 1);
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_nwords", wlog.size() - w0, 32);

    // Start+abort together while busy: abort only.
    a0 = abt_cnt; s0 = serr_cnt; d0 = done_cnt;
    pulse_start(64'd30, 16'd2);
    tick(); tick();
    cmd_start = 1'b1; cmd_abort = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    tick();
    chk("t6b_abort_cnt", abt_cnt - a0, 1);
    chk("t6b_serr_cnt", serr_cnt - s0, 0);
    chk("t6b_busy", busy, 0);
    repeat (8) tick();

    // Reset in the middle of WAIT.
    d0 = done_cnt; a0 = abt_cnt;
    pulse_start(64'd40, 16'd1);
    tick(); tick();
    ARESETN = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
    repeat (8) tick();
    chk("t7_busy", busy, 0);
    chk("t7_core_ctr", core_ctr, 0);
    chk("t7_blocks_done", blocks_done, 0);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_no_abort", abt_cnt - a0, 0);
    d0 = done_cnt;
    pulse_start(64'd7, 16'd1);
    wait_idle(0, "t7b");
    chk("t7b_done_cnt", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
